video_mode_ctrl: RTL and testbench
==================================

# video_mode_ctrl

Frame-synchronous display-mode controller for the video mux. It debounces the mode push-button and tracks pending mode-advance requests. An optional auto-cycle timer also advances the mode. The 2-bit mode select (`bg_out`, driving the mux `bg_in`) changes only on a frame-start pulse, so a mode switch never tears a frame. It sits between the board button/switch inputs and the mux, in the pixel clock domain.

## Interface
- `DEBOUNCE_CYCLES`, 16'd50000: consecutive stable cycles needed to accept a new button level (1..65535).
- `AUTO_FRAMES`, 8'd60: frames per automatic mode advance (1..255).
- `clk_in` input 1: pixel clock; all logic is on the rising edge.
- `rst_n_in` input 1: reset; asynchronous assert, active-low. Release is synchronous to `clk_in` by the board.
- `btn_in` input 1: raw, asynchronous, bouncy mode button; active-high.
- `new_frame_in` input 1: single-cycle pulse at the first pixel of each frame.
- `auto_en_in` input 1: level; enables auto-cycling.
- `pending_out` output 1: a mode change is queued for the next frame boundary.
- `bg_out` output 2: current mode to the mux: 00 camera, 01 bin overlay, 10 threshold b/w, 11 mask.
- `changed_out` output 1: one-cycle pulse, coincident with the cycle `bg_out` takes a new value.

## Operation
**Input conditioning**
- `btn_in` passes through a 2-flop synchronizer to give `btn_s`.
- Debouncer holds a level `btn_db`, reset value 0.
  - A 16-bit counter clears whenever `btn_s == btn_db`. Otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with `btn_s != btn_db`, `btn_db <= btn_s` and the counter clears.
- `press` is a one-cycle pulse on the 0->1 transition of `btn_db`. A 1->0 transition generates nothing.

**Target and state machine**
- The controller keeps a 2-bit `target` register.
- State IDLE (`target == bg_out`, `pending_out = 0`):
  - On `press`: `target <= bg_out + 1` (mod 4), then go to PENDING.
- State PENDING (`pending_out = 1`):
  - Each further `press`: `target <= target + 1` (mod 4). Presses accumulate without limit and wrap mod 4.
  - Four extra presses return `target` to the queued value. Wrapping back to `target == bg_out` still counts as PENDING and commits with `changed_out` asserted.
- Commit: on a cycle with `new_frame_in = 1` in PENDING:
  - `bg_out <= target_eff`, `changed_out <= 1`, go to IDLE.
  - `target_eff` is `target`, plus 1 if `press` is high in the same cycle.
- `press` and `new_frame_in` together in IDLE: commit immediately to `bg_out + 1`. No stay in PENDING.

**Auto-cycle**
- An 8-bit `frame_cnt` counts `new_frame_in` pulses while `auto_en_in = 1`.
- `frame_cnt` holds 0 while `auto_en_in = 0`. It also clears on any commit, including button commits.
- On a `new_frame_in` where `frame_cnt == AUTO_FRAMES-1` and the state is IDLE:
  - `bg_out <= bg_out + 1`, `changed_out <= 1`, `frame_cnt <= 0`.
- If a button commit occurs on that same boundary, the button commit wins. There is exactly one update, no additional auto increment, and `frame_cnt` clears.
- Deasserting `auto_en_in` mid-count clears `frame_cnt` on the next cycle.

**Reset**
- Asserting `rst_n_in` low, even mid-debounce or with a change pending, immediately forces:
  - `bg_out = 0`, `pending_out = 0`, `changed_out = 0`
  - `target = 0`, state IDLE, `frame_cnt = 0`, `btn_db = 0`, debounce counter 0, synchronizer flops 0.
- A queued request is discarded, not committed.

## Timing
- Button latency: 2 cycles of synchronizer plus `DEBOUNCE_CYCLES` cycles to `btn_db` rising. `press` occurs in the following cycle. `pending_out` is high one cycle after `press`.
- Commit latency: `bg_out` and `changed_out` update on the clock edge ending the `new_frame_in` cycle. They are visible the cycle after the pulse.
- `changed_out` is high for exactly one cycle per update; there is at most one update per frame.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Debounce. `DEBOUNCE_CYCLES=4`. Toggle `btn_in` every 2 cycles for 20 cycles, then hold it at 1 for 10 cycles.
  - Required: exactly one `press`; `pending_out` rises 7 cycles after the hold begins; `bg_out` stays 0 until a frame pulse.
- Frame-synchronous commit. With `bg_out=2`, press once, then pulse `new_frame_in` 100 cycles later.
  - Required: `bg_out` holds 2 until the pulse, becomes 3 the cycle after; one `changed_out` pulse; `pending_out` falls with it.
- Accumulate and wrap. With `bg_out=3`, make 3 debounced presses before the frame pulse.
  - Required: `bg_out=2` after the pulse (3+3 mod 4).
  - Then make 4 presses before the next frame. Required: `bg_out` stays 2, `changed_out` pulses.
- Auto vs button collision. `AUTO_FRAMES=3`, `auto_en_in=1`, `bg_out=0`. Button pending with target 1 at the third frame pulse.
  - Required: `bg_out=1` (not 2); `frame_cnt` restarts so the next auto step lands 3 frames later, to 2.
- Simultaneous press and frame in IDLE, `bg_out=1`.
  - Required: `bg_out=2` the next cycle; `pending_out` never asserts.
- Reset mid-operation. Assert `rst_n_in` low asynchronously (between edges) while PENDING with target 3 and `bg_out=1`.
  - Required: all outputs 0 immediately; after release, a frame pulse causes no change and no `changed_out`.

Source files
------------

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: debounced, frame-synchronous display-mode selector with optional auto-cycling
module video_mode_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  AUTO_FRAMES     = 8'd60
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       btn_in,
  input  logic       new_frame_in,
  input  logic       auto_en_in,
  output logic       pending_out,
  output logic [1:0] bg_out,
  output logic       changed_out
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t      state, state_nx;
  logic        sync_a, btn_s, btn_db, btn_db_q, press;
  logic [15:0] db_cnt;
  logic [1:0]  target, target_nx, bg_nx, target_eff;
  logic        changed_nx, commit, auto_hit;
  logic [7:0]  frame_cnt, frame_cnt_nx;
  // bring the raw button into the pixel clock domain
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) {btn_s, sync_a} <= 2'b00;
    else {btn_s, sync_a} <= {sync_a, btn_in};
  // accept a new button level only after it has been stable long enough
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) db_cnt <= '0;
      else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 16'd1;
    end
  assign press       = btn_db & ~btn_db_q;
  assign commit      = new_frame_in & ((state == PENDING) | press);
  assign target_eff  = (state == PENDING) ? target + {1'b0, press} : bg_out + 2'd1;
  assign auto_hit    = new_frame_in & auto_en_in & (state == IDLE) & (frame_cnt == AUTO_FRAMES - 8'd1);
  assign pending_out = (state == PENDING);
  // next mode, queued target and auto-cycle count; a button commit beats the auto step
  always_comb begin
    state_nx     = state;
    target_nx    = target;
    bg_nx        = bg_out;
    changed_nx   = 1'b0;
    frame_cnt_nx = auto_en_in ? frame_cnt + {7'd0, new_frame_in} : 8'd0;
    if (commit) begin
      state_nx     = IDLE;
      target_nx    = target_eff;
      bg_nx        = target_eff;
      changed_nx   = 1'b1;
      frame_cnt_nx = 8'd0;
    end else if (press) begin
      state_nx  = PENDING;
      target_nx = target_eff;
    end else if (auto_hit) begin
      target_nx    = bg_out + 2'd1;
      bg_nx        = bg_out + 2'd1;
      changed_nx   = 1'b1;
      frame_cnt_nx = 8'd0;
    end
  end
  // controller state register; reset discards any queued request
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state       <= IDLE;
      target      <= 2'd0;
      bg_out      <= 2'd0;
      changed_out <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      state       <= state_nx;
      target      <= target_nx;
      bg_out      <= bg_nx;
      changed_out <= changed_nx;
      frame_cnt   <= frame_cnt_nx;
    end
endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: directed and randomized checks of video_mode_ctrl against a request-count model
module tb_video_mode_ctrl;
  localparam int DB = 4;
  localparam int AF = 3;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn = 1'b0, new_frame = 1'b0, auto_en = 1'b0;
  logic       pending, changed;
  logic [1:0] bg;
  int checks = 0, fails = 0;
  int m_bg = 0, m_req = 0, m_fcnt = 0, m_chg = 0;

  video_mode_ctrl #(.DEBOUNCE_CYCLES(16'(DB)), .AUTO_FRAMES(8'(AF))) dut (
    .clk_in(clk), .rst_n_in(rst_n), .btn_in(btn), .new_frame_in(new_frame),
    .auto_en_in(auto_en), .pending_out(pending), .bg_out(bg), .changed_out(changed));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".bg"}, bg, 2'(m_bg));
    chk({tag, ".pending"}, {1'b0, pending}, 2'(m_req > 0));
    chk({tag, ".changed"}, {1'b0, changed}, 2'(m_chg));
  endtask

  // one frame boundary seen by the model, optionally with a press in the same cycle
  task automatic model_frame(input bit with_press);
    if (with_press) m_req++;
    m_chg = 0;
    if (m_req > 0) begin
      m_bg = (m_bg + m_req) % 4;
      m_req = 0;
      m_fcnt = 0;
      m_chg = 1;
    end else if (auto_en && m_fcnt == AF - 1) begin
      m_bg = (m_bg + 1) % 4;
      m_fcnt = 0;
      m_chg = 1;
    end else if (auto_en) m_fcnt++;
  endtask

  task automatic frame(input string tag);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    model_frame(0);
    chk_all({tag, ".commit"});
    tick();
    m_chg = 0;
    chk_all({tag, ".after"});
  endtask

  // bouncy press; the accepted press lands 6 edges after the final hold begins
  task automatic press(input string tag, input bit with_frame);
    int n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      btn = 1'b1;
      repeat ($urandom_range(1, 2)) tick();
      btn = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
    end
    btn = 1'b1;
    repeat (6) tick();
    if (with_frame) begin
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      model_frame(1);
    end else begin
      tick();
      m_req++;
      m_chg = 0;
    end
    chk_all({tag, ".press"});
    btn = 1'b0;
    repeat (8) tick();
    m_chg = 0;
    chk_all({tag, ".release"});
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    chk_all("reset");
    rst_n = 1'b1;
    tick();
    chk_all("reset.release");

    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0);
      tick();
    end
    btn = 1'b1;
    repeat (6) tick();
    chk("debounce.early", {1'b0, pending}, 2'd0);
    tick();
    chk("debounce.pending7", {1'b0, pending}, 2'd1);
    m_req++;
    repeat (3) tick();
    chk_all("debounce.hold");
    btn = 1'b0;
    repeat (8) tick();
    frame("debounce.frame");

    press("to2", 0);
    frame("to2.frame");
    press("c100", 0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk_all("c100.wait");
    end
    frame("c100.frame");

    for (int i = 0; i < 3; i++) press("acc3", 0);
    frame("acc3.frame");
    for (int i = 0; i < 4; i++) press("acc4", 0);
    frame("acc4.frame");

    press("to0", 0);
    press("to0", 0);
    frame("to0.frame");
    auto_en = 1'b1;
    tick();
    frame("auto.f1");
    frame("auto.f2");
    press("coll", 0);
    frame("coll.f3");
    frame("auto.f4");
    frame("auto.f5");
    frame("auto.f6");
    auto_en = 1'b0;
    tick();
    m_fcnt = 0;

    for (int i = 0; i < 3; i++) press("to1", 0);
    frame("to1.frame");
    press("simul", 1);
    tick();
    chk_all("simul.next");

    for (int i = 0; i < 3; i++) press("rto1", 0);
    frame("rto1.frame");
    press("rt3", 0);
    press("rt3", 0);
    #3;
    rst_n = 1'b0;
    #1;
    m_bg = 0;
    m_req = 0;
    m_fcnt = 0;
    m_chg = 0;
    chk_all("rst.async");
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("rst.released");
    frame("rst.frame");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0, 1: press("rnd.press", 0);
        2: frame("rnd.frame");
        3: press("rnd.pf", 1);
        default: begin
          auto_en = ~auto_en;
          tick();
          if (!auto_en) m_fcnt = 0;
          chk_all("rnd.auto");
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
